parity_error_checker: RTL and testbench



---
 rtl/parity_error_checker.sv | 57 +++++
 tb/tb_parity_error_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/parity_error_checker.sv
// rtl/parity_error_checker.sv - registered parity checker with sticky flag and saturating error counter
module parity_error_checker #(
  parameter int DATA_W     = 6,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  output logic              error,
  output logic              error_sticky,
  output logic [CNT_W-1:0]  error_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             ODD_SEL = (ODD_PARITY != 0);

  // Parity of the word under check; ODD_SEL flips the sense so that
  // perr is 1 whenever the word violates the selected parity scheme.
  logic perr;
  assign perr = (^data) ^ ODD_SEL;

  // Per-word error flag: one clock of latency, follows every sampled word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else begin
      error <= perr;
    end
  end

  // Sticky flag: an error on the same edge as clear wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_sticky <= 1'b0;
    end else if (perr) begin
      error_sticky <= 1'b1;
    end else if (clear) begin
      error_sticky <= 1'b0;
    end
  end

  // Saturating error counter; clear restarts from 0, or from 1 when the
  // word sampled on the clearing edge is itself in error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_count <= '0;
    end else if (clear) begin
      error_count <= perr ? CNT_ONE : '0;
    end else if (perr && (error_count != CNT_MAX)) begin
      error_count <= error_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_parity_error_checker.sv
// tb/tb_parity_error_checker.sv - directed self-checking bench for parity_error_checker
module tb_parity_error_checker;

  logic       clk;
  logic       rst;
  logic [5:0] data;
  logic       clear;

  logic       error,     sticky;
  logic [7:0] count;
  logic       sat_error, sat_sticky;
  logic [2:0] sat_count;
  logic       odd_error, odd_sticky;
  logic [7:0] odd_count;

  int checks;
  int errors;

  parity_error_checker #(.DATA_W(6), .ODD_PARITY(0), .CNT_W(8)) u_even (
    .clk(clk), .rst(rst), .data(data), .clear(clear),
    .error(error), .error_sticky(sticky), .error_count(count)
  );

  parity_error_checker #(.DATA_W(6), .ODD_PARITY(0), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .data(data), .clear(clear),
    .error(sat_error), .error_sticky(sat_sticky), .error_count(sat_count)
  );

  parity_error_checker #(.DATA_W(6), .ODD_PARITY(1), .CNT_W(8)) u_odd (
    .clk(clk), .rst(rst), .data(data), .clear(clear),
    .error(odd_error), .error_sticky(odd_sticky), .error_count(odd_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0; data = 6'b000011;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++;
    if (sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", sticky); end
    checks++;
    if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    step();
    rst = 1'b0; data = 6'b000000;
    step();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL reset_first_edge: got %b expected 0", error); end
  endtask

  task automatic test_even_words();
    logic [5:0] words [3];
    words[0] = 6'b000000; words[1] = 6'b100001; words[2] = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      data = words[i];
      step();
      checks++;
      if (error !== 1'b0 || count !== 8'd0 || sticky !== 1'b0) begin
        errors++;
        $display("FAIL even_word_%0d: got error=%b count=%0d sticky=%b expected 0/0/0", i, error, count, sticky);
      end
    end
  endtask

  task automatic test_odd_word();
    data = 6'b000001;
    step();
    checks++;
    if (error !== 1'b1 || sticky !== 1'b1 || count !== 8'd1) begin
      errors++;
      $display("FAIL odd_word: got error=%b sticky=%b count=%0d expected 1/1/1", error, sticky, count);
    end
    data = 6'b000011;
    step();
    checks++;
    if (error !== 1'b0 || sticky !== 1'b1 || count !== 8'd1) begin
      errors++;
      $display("FAIL odd_word_after: got error=%b sticky=%b count=%0d expected 0/1/1", error, sticky, count);
    end
  endtask

  task automatic test_held_error();
    clear = 1'b1; data = 6'b000000;
    step();
    clear = 1'b0; data = 6'b000111;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (error !== 1'b1 || count !== 8'(i)) begin
        errors++;
        $display("FAIL held_error_%0d: got error=%b count=%0d expected 1/%0d", i, error, count, i);
      end
    end
  endtask

  task automatic test_clear();
    clear = 1'b1; data = 6'b000000;
    step();
    checks++;
    if (count !== 8'd0 || sticky !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL clear_clean: got count=%0d sticky=%b error=%b expected 0/0/0", count, sticky, error);
    end
    data = 6'b000001;
    step();
    checks++;
    if (count !== 8'd1 || sticky !== 1'b1 || error !== 1'b1) begin
      errors++;
      $display("FAIL clear_with_error: got count=%0d sticky=%b error=%b expected 1/1/1", count, sticky, error);
    end
    clear = 1'b0;
  endtask

  task automatic test_saturation();
    int exp;
    clear = 1'b1; data = 6'b000000;
    step();
    clear = 1'b0; data = 6'b000001;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = (i > 7) ? 7 : i;
      checks++;
      if (sat_count !== 3'(exp)) begin
        errors++;
        $display("FAIL saturation_%0d: got %0d expected %0d", i, sat_count, exp);
      end
    end
  endtask

  task automatic test_odd_mode();
    data = 6'b000000;
    step();
    checks++;
    if (odd_error !== 1'b1) begin errors++; $display("FAIL odd_mode_zero: got %b expected 1", odd_error); end
    data = 6'b000001;
    step();
    checks++;
    if (odd_error !== 1'b0) begin errors++; $display("FAIL odd_mode_one: got %b expected 0", odd_error); end
  endtask

  task automatic test_mid_reset();
    data = 6'b000001;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (error !== 1'b0 || sticky !== 1'b0 || count !== 8'd0 || sat_count !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: got error=%b sticky=%b count=%0d sat_count=%0d expected 0/0/0/0", error, sticky, count, sat_count);
    end
    step();
    checks++;
    if (error !== 1'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL reset_held: got error=%b count=%0d expected 0/0", error, count);
    end
    rst = 1'b0; data = 6'b000000;
    step();
    checks++;
    if (error !== 1'b0 || count !== 8'd0 || sticky !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got error=%b count=%0d sticky=%b expected 0/0/0", error, count, sticky);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_even_words();
    test_odd_word();
    test_held_error();
    test_clear();
    test_saturation();
    test_odd_mode();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
